// File: rtl/received_num_tx_formatter.sv
// Serialises captured {address, data} words into MSG_ID/FLAGS/ADDR/DATA byte messages for the UART.
// Optional feature macro: RX_NUM_TX_CHECKSUM_EN appends a zero-sum checksum byte.
module received_num_tx_formatter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [7:0]  MSG_ID     = 8'h03
) (
    input  logic                             clk,
    input  logic                             n_reset,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] in_packet,
    input  logic                             in_valid,
    input  logic                             in_overrun,
    output logic                             in_ack,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             busy
);
    localparam int unsigned PKT_W      = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 32'd7) / 32'd8;
    localparam int unsigned DATA_BYTES = (DATA_WIDTH + 32'd7) / 32'd8;
    localparam int unsigned ADDR_EXT_W = ADDR_BYTES * 32'd8;
    localparam int unsigned DATA_EXT_W = DATA_BYTES * 32'd8;
    localparam logic [2:0]  ADDR_TOP   = 3'(ADDR_BYTES - 32'd1);
    localparam logic [2:0]  DATA_TOP   = 3'(DATA_BYTES - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FLAGS = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4
`ifdef RX_NUM_TX_CHECKSUM_EN
        ,
        ST_CSUM  = 3'd5
`endif
    } state_t;

    function automatic logic [7:0] addr_byte(input logic [ADDR_EXT_W-1:0] v, input logic [2:0] idx);
        logic [ADDR_EXT_W-1:0] sh;
        sh = v >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [7:0] data_byte(input logic [DATA_EXT_W-1:0] v, input logic [2:0] idx);
        logic [DATA_EXT_W-1:0] sh;
        sh = v >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [PKT_W-1:0]        pkt_q, pkt_d;
    logic                    ovr_q, ovr_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    in_ack_q, in_ack_d;
    logic                    busy_q;
    logic                    xfer_s;
    logic [ADDR_EXT_W-1:0]   addr_ext_s;
    logic [DATA_EXT_W-1:0]   data_ext_s;
`ifdef RX_NUM_TX_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    assign xfer_s = tx_valid_q & tx_ready;

    // Zero-extend the captured fields to whole bytes at the MSB end
    always_comb begin
        addr_ext_s                   = '0;
        data_ext_s                   = '0;
        addr_ext_s[ADDR_WIDTH-1:0]   = pkt_q[PKT_W-1 -: ADDR_WIDTH];
        data_ext_s[DATA_WIDTH-1:0]   = pkt_q[DATA_WIDTH-1:0];
    end

    // Next-state logic: each state presents one byte and loads the next only on a transfer
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pkt_d      = pkt_q;
        ovr_d      = ovr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        in_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pkt_d      = in_packet;
                    ovr_d      = in_overrun;
                    in_ack_d   = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = MSG_ID;
                    state_d    = ST_HDR;
                end else begin
                    tx_valid_d = 1'b0;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    tx_data_d = {7'd0, ovr_q};
                    state_d   = ST_FLAGS;
                end else begin
                    state_d   = ST_HDR;
                end
            end
            ST_FLAGS: begin
                if (xfer_s) begin
                    tx_data_d = addr_byte(addr_ext_s, ADDR_TOP);
                    idx_d     = ADDR_TOP;
                    state_d   = ST_ADDR;
                end else begin
                    state_d   = ST_FLAGS;
                end
            end
            ST_ADDR: begin
                if (!xfer_s) begin
                    state_d = ST_ADDR;
                end else if (idx_q == 3'd0) begin
                    tx_data_d = data_byte(data_ext_s, DATA_TOP);
                    idx_d     = DATA_TOP;
                    state_d   = ST_DATA;
                end else begin
                    tx_data_d = addr_byte(addr_ext_s, idx_q - 3'd1);
                    idx_d     = idx_q - 3'd1;
                end
            end
            ST_DATA: begin
                if (!xfer_s) begin
                    state_d = ST_DATA;
                end else if (idx_q == 3'd0) begin
`ifdef RX_NUM_TX_CHECKSUM_EN
                    // Byte on the wire now is not yet in the accumulator
                    tx_data_d  = 8'h00 - (csum_q + tx_data_q);
                    state_d    = ST_CSUM;
`else
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
`endif
                end else begin
                    tx_data_d = data_byte(data_ext_s, idx_q - 3'd1);
                    idx_d     = idx_q - 3'd1;
                end
            end
`ifdef RX_NUM_TX_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer_s) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_CSUM;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

`ifdef RX_NUM_TX_CHECKSUM_EN
    // Running mod-256 sum of transferred bytes, cleared at capture
    always_comb begin
        if ((state_q == ST_IDLE) && in_valid) begin
            csum_d = 8'h00;
        end else if (xfer_s) begin
            csum_d = csum_q + tx_data_q;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // State, capture and output registers; reset aborts any message in flight
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            pkt_q      <= '0;
            ovr_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            in_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pkt_q      <= pkt_d;
            ovr_q      <= ovr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            in_ack_q   <= in_ack_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign in_ack   = in_ack_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_received_num_tx_formatter.sv
// Randomised self-checking bench for received_num_tx_formatter; expected messages come from a byte-list model.
module tb_received_num_tx_formatter;
    logic        clk;
    logic        n_reset;
    logic [23:0] in_packet;
    logic        in_valid;
    logic        in_overrun;
    logic        in_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    logic [21:0] w_in_packet;
    logic        w_in_valid;
    logic        w_in_overrun;
    logic        w_in_ack;
    logic [7:0]  w_tx_data;
    logic        w_tx_valid;
    logic        w_tx_ready;
    logic        w_busy;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];

    received_num_tx_formatter dut (
        .clk(clk), .n_reset(n_reset), .in_packet(in_packet), .in_valid(in_valid),
        .in_overrun(in_overrun), .in_ack(in_ack), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy)
    );

    received_num_tx_formatter #(.ADDR_WIDTH(10), .DATA_WIDTH(12), .MSG_ID(8'h03)) dut2 (
        .clk(clk), .n_reset(n_reset), .in_packet(w_in_packet), .in_valid(w_in_valid),
        .in_overrun(w_in_overrun), .in_ack(w_in_ack), .tx_data(w_tx_data), .tx_valid(w_tx_valid),
        .tx_ready(w_tx_ready), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: message as a list of bytes built from the field values
    task automatic build_expected(input logic [31:0] addr, input logic [31:0] data,
                                  input int aw, input int dw, input logic ovr);
        int ab;
        int db;
        int sum;
        ab  = (aw + 7) / 8;
        db  = (dw + 7) / 8;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'h03);
        exp_q.push_back({7'd0, ovr});
        for (int i = ab - 1; i >= 0; i--) exp_q.push_back(8'((addr >> (8 * i)) & 32'hFF));
        for (int i = db - 1; i >= 0; i--) exp_q.push_back(8'((data >> (8 * i)) & 32'hFF));
`ifdef RX_NUM_TX_CHECKSUM_EN
        foreach (exp_q[i]) sum += int'(exp_q[i]);
        exp_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1,0,1 repeating, 2: random ready
    task automatic run_msg(input logic [23:0] pkt, input logic ovr, input int mode,
                           input bit hold, input string name);
        logic [7:0] got[$];
        bit         ready_pat[6];
        int         acks;
        int         last_cyc;
        bit         done;
        bit         prev_stall;
        logic [7:0] prev_data;
        ready_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        acks       = 0;
        last_cyc   = 0;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        build_expected(32'(pkt[23:16]), 32'(pkt[15:0]), 8, 16, ovr);
        in_packet  = pkt;
        in_overrun = ovr;
        in_valid   = 1'b1;
        tx_ready   = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (in_ack !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h03) begin
                    failures++;
                    $display("FAIL %s_cycle1: ack=%b valid=%b data=%h required ack=1 valid=1 data=03",
                             name, in_ack, tx_valid, tx_data);
                end
                if (!hold) in_valid = 1'b0;
            end
            if (in_ack === 1'b1) acks++;
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    failures++;
                    $display("FAIL %s_stall_hold cyc=%0d: valid=%b data=%h required valid=1 data=%h",
                             name, cyc, tx_valid, tx_data, prev_data);
                end
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ready_pat[(cyc - 1) % 6];
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid === 1'b1 && tx_ready) begin
                got.push_back(tx_data);
                last_cyc = cyc;
            end
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            if (got.size() == exp_q.size()) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: bytes=%0d required %0d", name, got.size(), exp_q.size());
        end else begin
            @(negedge clk);
            if (in_ack === 1'b1) acks++;
            checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_end_idle: valid=%b busy=%b required 0 0", name, tx_valid, busy);
            end
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL %s_ack_count: got %0d required 1", name, acks);
        end
        if (mode == 0 && done) begin
            checks++;
            if (last_cyc != exp_q.size()) begin
                failures++;
                $display("FAIL %s_last_cycle: got %0d required %0d", name, last_cyc, exp_q.size());
            end
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_byte%0d: got %h required %h", name, i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic drain(input string name);
        bit idle;
        idle     = 1'b0;
        in_valid = 1'b0;
        tx_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL %s_drain: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || in_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: valid=%b data=%h busy=%b ack=%b required 0 00 0 0",
                     tx_valid, tx_data, busy, in_ack);
        end
        n_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || w_tx_valid !== 1'b0 || w_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b busy=%b wvalid=%b wbusy=%b required all 0",
                     tx_valid, busy, w_tx_valid, w_busy);
        end
    endtask

    task automatic test_basic();
        run_msg(24'h05_1234, 1'b0, 0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        run_msg(24'h05_1234, 1'b0, 1, 1'b0, "stall");
    endtask

    task automatic test_hold_overrun();
        run_msg(24'hC3_00FF, 1'b1, 0, 1'b1, "hold");
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b1) begin
            failures++;
            $display("FAIL hold_second_ack: ack=%b required 1", in_ack);
        end
        drain("hold");
    endtask

    task automatic test_reset_mid();
        in_packet  = 24'h05_1234;
        in_overrun = 1'b0;
        in_valid   = 1'b1;
        tx_ready   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_data !== 8'h05 || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_addr: data=%h valid=%b required 05 1", tx_data, tx_valid);
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b busy=%b required 0 0", tx_valid, busy);
        end
        #2;
        n_reset = 1'b1;
        run_msg(24'hA7_BEEF, 1'b0, 0, 1'b0, "midrst_fresh");
    endtask

    task automatic test_wide(input logic [9:0] a, input logic [11:0] d, input string name);
        logic [7:0] got[$];
        int         acks;
        acks = 0;
        build_expected(32'(a), 32'(d), 10, 12, 1'b0);
        w_in_packet  = {a, d};
        w_in_overrun = 1'b0;
        w_in_valid   = 1'b1;
        w_tx_ready   = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0;
        for (int cyc = 1; cyc <= exp_q.size(); cyc++) begin
            if (w_in_ack === 1'b1) acks++;
            if (w_tx_valid === 1'b1) got.push_back(w_tx_data);
            @(negedge clk);
        end
        checks++;
        if (w_tx_valid !== 1'b0 || w_busy !== 1'b0 || acks != 1) begin
            failures++;
            $display("FAIL %s_end: valid=%b busy=%b acks=%0d required 0 0 1", name, w_tx_valid, w_busy, acks);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len: got %0d required %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_byte%0d: got %h required %h", name, i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_msg(24'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, "random");
        end
    endtask

    initial begin
        n_reset      = 1'b0;
        in_packet    = 24'h00_0000;
        in_valid     = 1'b0;
        in_overrun   = 1'b0;
        tx_ready     = 1'b0;
        w_in_packet  = 22'h00_0000;
        w_in_valid   = 1'b0;
        w_in_overrun = 1'b0;
        w_tx_ready   = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_hold_overrun();
        test_reset_mid();
        test_wide(10'h2A5, 12'hABC, "wide");
        test_wide(10'($urandom), 12'($urandom), "wide_rand");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/received_num_tx_formatter.md
# received_num_tx_formatter

Downstream consumer of the memory manager's received-number output. It takes each captured {address, data} word offered on the valid/ack handshake and acknowledges it. It then serialises the word into a fixed-format byte message for the UART transmitter, using a byte-wide valid/ready stream. It is the only path by which sampled delay-line contents return to the host.

## Interface
Parameters:
- ADDR_WIDTH, default 8: address field width, 1–16.
- DATA_WIDTH, default 16: data field width, 1–32.
- MSG_ID, default 8'h03: header byte identifying a received-number message.

Ports:
- clk, input, 1: sole clock.
- n_reset, input, 1: asynchronous, active-low reset.
- in_packet, input, ADDR_WIDTH+DATA_WIDTH: address in the upper ADDR_WIDTH bits, data in the lower DATA_WIDTH bits.
- in_valid, input, 1: in_packet is valid. The upstream block drops it combinationally while in_ack is high.
- in_overrun, input, 1: upstream overrun flag, sampled at capture.
- in_ack, output, 1: one-cycle pulse; the packet has been consumed.
- tx_data, output, 8: byte to the UART transmitter.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: the transmitter accepts the byte. A transfer occurs when tx_valid and tx_ready are both high on a rising edge.
- busy, output, 1: high in every state except IDLE.

## Operation
- ADDR_BYTES = ceil(ADDR_WIDTH/8); DATA_BYTES = ceil(DATA_WIDTH/8). Each field is zero-extended at the MSB end to a whole number of bytes.
- Message byte order:
  - MSG_ID.
  - FLAGS: bit0 = captured overrun; bits 7:1 = 0.
  - Address bytes, MSB first.
  - Data bytes, MSB first.
  - [CSUM].
- States and transitions:
  - IDLE: when in_valid = 1, capture in_packet and in_overrun, pulse in_ack, go to HDR.
  - HDR → FLAGS → ADDR → DATA → (CSUM | IDLE). Each state advances only on a transfer.
  - ADDR and DATA use a byte index counter. It resets to ADDR_BYTES-1 or DATA_BYTES-1 on entry and decrements per transfer. The state exits on the transfer made with index 0.
- tx_data and tx_valid are registered. While tx_valid = 1 and tx_ready = 0, tx_data stays stable and tx_valid stays high.
- in_valid is ignored outside IDLE. The capture register is not overwritten until the message completes. Loss is reported by upstream through in_overrun on a later message.
- Reset values: state IDLE, in_ack 0, tx_valid 0, tx_data 8'h00, busy 0, capture registers 0, checksum accumulator 0.
- Asserting n_reset mid-message aborts immediately and the partial message is discarded. No resume occurs.

## Timing
- Cycle 0: in_valid is sampled high in IDLE.
- Cycle 1: in_ack = 1 (exactly one cycle), tx_valid = 1, tx_data = MSG_ID.
- With tx_ready held high, one byte transfers per cycle. The last byte transfers in cycle 1 + N - 1, where N = 2 + ADDR_BYTES + DATA_BYTES [+1].
- The FSM is in IDLE the cycle after the last transfer. tx_valid is 0 in that cycle.
- The next in_valid can therefore be sampled no earlier than cycle N+1. A one-cycle gap between messages is required.
- tx_ready may toggle arbitrarily. Only transfer cycles advance state.
- in_ack never asserts outside the cycle that follows an IDLE capture.

## Configuration
- RX_NUM_TX_CHECKSUM_EN defined:
  - A CSUM state follows DATA.
  - CSUM byte = two's complement of the mod-256 sum of all preceding message bytes, so all bytes of the message sum to 0 mod 256.
  - The accumulator clears on capture and adds each transferred byte.
- RX_NUM_TX_CHECKSUM_EN undefined: no CSUM state and no accumulator logic; DATA returns directly to IDLE.

## Test plan
- Defaults with checksum enabled, in_packet = 24'h05_1234, in_overrun = 0, tx_ready = 1:
  - in_ack pulses once in cycle 1.
  - Bytes 03, 00, 05, 12, 34, B2 in cycles 1–6.
  - busy falls in cycle 7.
- Same stimulus with checksum disabled: bytes 03, 00, 05, 12, 34 only; tx_valid is 0 in cycle 6.
- tx_ready pattern 1,0,0,1,0,1…: each byte holds stable while stalled; no byte is dropped or duplicated; the byte sequence matches the first scenario.
- in_valid held high through an entire message with in_overrun = 1: exactly one in_ack per message; the FLAGS byte = 01; a second ack occurs only after a return to IDLE.
- n_reset pulsed low during the ADDR byte: tx_valid and busy go to 0 asynchronously. After release with in_valid = 1, a fresh message starts with MSG_ID.
- ADDR_WIDTH = 10, DATA_WIDTH = 12, in_packet = {10'h2A5, 12'hABC}: address bytes 02, A5; data bytes 0A, BC.
